// File: rtl/glip_scale_pkg.sv
// Width-ratio helpers shared by the FIFO upscaler and downscaler.
// Pure functions evaluated at elaboration; no logic.
// No handshake of its own.
package glip_scale_pkg;

  // Returns the narrow-to-wide word ratio, or 0 when the pair is not supported.
  function automatic int scale_ratio(input int in_size, input int out_size);
    if (out_size == in_size)     return 1;
    if (out_size == 2 * in_size) return 2;
    if (out_size == 4 * in_size) return 4;
    return 0;
  endfunction

  function automatic int cnt_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/glip_upscale.sv
// Packs RATIO narrow FIFO words, MSB-first, into one registered wide word.
// Latency: out_valid rises 1 cycle after the final narrow word is accepted.
// Backpressure: non-final words are always taken; the final word waits for a free or draining output slot.
module glip_upscale
  import glip_scale_pkg::*;
#(
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = IN_SIZE * 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_SIZE-1:0]  in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_SIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                partial
);

  localparam int RATIO = scale_ratio(IN_SIZE, OUT_SIZE);
  localparam int CW    = cnt_width(RATIO);
  localparam logic [CW-1:0] LAST = CW'((RATIO > 0) ? RATIO - 1 : 0);

  logic [CW-1:0]       cnt;
  logic [OUT_SIZE-1:0] oreg;
  logic                ovalid;
  logic [OUT_SIZE-1:0] wide;
  logic                is_last;
  logic                in_xfer;
  logic                out_xfer;

  assign is_last   = (cnt == LAST);
  assign in_ready  = !is_last || !ovalid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = ovalid && out_ready;
  assign out_data  = oreg;
  assign out_valid = ovalid;
  assign partial   = (cnt != '0);

  if (RATIO == 0) begin : g_bad
    $fatal(1, "glip_upscale: OUT_SIZE must be 1, 2 or 4 times IN_SIZE");
    assign wide = '0;
  end else if (RATIO == 1) begin : g_pass
    assign wide = in_data;
  end else begin : g_asm
    // Slot 0 sits in the most significant position of the packed vector.
    logic [0:RATIO-2][IN_SIZE-1:0] asm;
    for (genvar s = 0; s < RATIO - 1; s++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          asm[s] <= '0;
        end else if (in_xfer && !is_last && cnt == CW'(s)) begin
          asm[s] <= in_data;
        end
      end
    end
    assign wide = {asm, in_data};
  end

  // A drain and a final-word load in the same cycle keep ovalid high: no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      oreg   <= '0;
      ovalid <= 1'b0;
    end else begin
      if (out_xfer) begin
        ovalid <= 1'b0;
      end
      if (in_xfer) begin
        if (is_last) begin
          oreg   <= wide;
          ovalid <= 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/glip_upscale.md
Name: glip_upscale

Overview:
- Receive-side counterpart of the 2:1 FIFO downscaler.
- Collects RATIO consecutive narrow words from a FIFO interface and emits one wide word, MSB-first: the first word received becomes the upper part. This matches the order in which the downscaler emits upper then lower.
- Sits between the narrow link-side FIFO and the wide logic-side FIFO.
- Output is registered with one slot of buffering, so a continuous input stream never stalls while the output is drained.

Parameters:
- IN_SIZE, 8: input word width in bits.
- OUT_SIZE, IN_SIZE*2: output word width in bits. OUT_SIZE must be IN_SIZE, 2*IN_SIZE or 4*IN_SIZE. Any other value triggers $fatal at elaboration.
- RATIO (derived localparam), OUT_SIZE/IN_SIZE: number of input words per output word (1, 2 or 4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  IN_SIZE  narrow input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input word this cycle.
- out_data  out  OUT_SIZE  assembled wide word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- partial  out  1  1 while a wide word is partly assembled (cnt != 0).

Behaviour:
- Handshakes
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - out_data and out_valid are register outputs. out_data is held stable while out_valid & !out_ready.
- State
  - cnt: 0..RATIO-1, width clog2(RATIO), minimum 1 bit.
  - asm: (RATIO-1)*IN_SIZE bits; unused when RATIO=1.
  - oreg: out_data register. ovalid: out_valid register.
- Reset: cnt=0, ovalid=0, oreg=0, partial=0. A partly assembled word is discarded.
- in_ready = (cnt != RATIO-1) | !ovalid | out_ready.
  - Non-final words are always accepted.
  - The final word is accepted only when the output slot is free or draining this cycle.
- Non-final input transfer (cnt < RATIO-1):
  - Store in_data into asm slot cnt; slot 0 is the most significant.
  - cnt <= cnt+1.
- Final input transfer (cnt == RATIO-1):
  - oreg <= {asm slots 0..RATIO-2, in_data}; ovalid <= 1; cnt <= 0.
- Output transfer without a final input transfer in the same cycle: ovalid <= 0.
- Simultaneous output transfer and final input transfer: oreg reloads and ovalid stays 1. No bubble.
- Latency: out_valid rises 1 cycle after the final input word's transfer cycle.
- Throughput: one wide word per RATIO input cycles when out_ready=1.
- Backpressure:
  - With ovalid=1 and out_ready=0, up to RATIO-1 further words are accepted into asm.
  - The final word is then blocked: in_ready=0 until out_ready.
- RATIO=1: pure registered pipeline stage; in_ready = !ovalid | out_ready; cnt stays 0; partial is constant 0.
- partial = (cnt != 0), combinational from the register.
- in_data is ignored when in_valid=0. No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only.
- Reset mid-word (cnt != 0): takes priority over all transfers; the next accepted word becomes slot 0.

Decomposition:
- Shared package glip_scale_pkg:
  - function scale_ratio(in_size, out_size), returning 0 if illegal.
  - function cnt_width(ratio).
  - Shared with the downscaler for its own legality check.
- No sub-module. The output register is inline; a separate skid module adds no value at one slot.

Test Plan:
- IN=8, OUT=16, out_ready=1; inputs 0xAB, 0xCD on consecutive cycles -> out_data=0xABCD, out_valid=1 for exactly 1 cycle, 1 cycle after the 0xCD transfer; partial=1 between the two words.
- IN=8, OUT=16, continuous stream 0x01..0x08, out_ready=1 -> outputs 0x0102, 0x0304, 0x0506, 0x0708 every 2 cycles; in_ready constantly 1.
- IN=8, OUT=32, out_ready=0 after first output 0x11223344:
  - next words 0x55, 0x66, 0x77 accepted, 0x88 stalled (in_ready=0);
  - out_data holds 0x11223344;
  - on out_ready=1, 0x88 is accepted the same cycle, and 0x55667788 appears the next cycle with out_valid held 1.
- IN=8, OUT=16: rst asserted after 0xEE accepted (partial=1) -> after reset, inputs 0x12, 0x34 give 0x1234; 0xEE never appears; all outputs 0 during reset.
- IN=OUT=8, random in_valid/out_ready (1000 words) -> output sequence equals input sequence, no loss or duplication, 1-cycle latency when unstalled.
- Loopback: glip_downscale(16->8) feeding glip_upscale(8->16), random stalls on both ends -> 16-bit output stream bit-identical to input stream.
